// File: rtl/qsys_onchip_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qsys_onchip_mem_pkg
//  Description : Shared constants, helpers and the per-port command record
//                for the dual-port on-chip memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package qsys_onchip_mem_pkg;

    localparam int RL_ONE = 1;
    localparam int RL_TWO = 2;

    // Upper bounds for the command record; the top zero-extends into these.
    localparam int MAX_ADDR_W = 32;
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    function automatic int calc_be_w(input int data_w);
        return data_w / 8;
    endfunction

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_BE_W-1:0]   be;
        logic                  rd;
        logic                  wr;
        logic [MAX_DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage : qsys_onchip_mem_pkg
`default_nettype wire

// File: rtl/onchip_mem_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : onchip_mem_rd_pipe
//  Description : Read-return shift register (valid + data) of depth LATENCY
//                with synchronous reset and a hold-when-disabled enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_rd_pipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic [LATENCY-1:0]             valid_q, valid_d;
    logic [LATENCY-1:0][DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_en) begin
            valid_d[0] = i_valid;
            data_d[0]  = i_valid ? i_data : '0;
            for (int i = 1; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // A frozen pipe keeps its head entry; hiding it while disabled means the
    // master sees each return exactly once, in the first enabled cycle.
    assign o_valid = valid_q[LATENCY-1] & i_en;
    assign o_data  = data_q[LATENCY-1];

endmodule : onchip_mem_rd_pipe
`default_nettype wire

// File: rtl/qsys_onchip_mem_dp.sv
`default_nettype none
// ============================================================================
//  Module      : qsys_onchip_mem_dp
//  Description : Dual-port Avalon-MM on-chip RAM with byte lanes, registered
//                reads (latency 1 or 2) and same-address write arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module qsys_onchip_mem_dp
    import qsys_onchip_mem_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 5120,
    parameter int    ADDR_W       = 13,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "qsys_onchip_mem.hex",
    localparam int   BE_W         = calc_be_w(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic              reset_req,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic              s1_chipselect,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    output logic              s1_waitrequest,
    input  logic [ADDR_W-1:0] s2_address,
    input  logic [BE_W-1:0]   s2_byteenable,
    input  logic              s2_chipselect,
    input  logic              s2_read,
    input  logic              s2_write,
    input  logic [DATA_W-1:0] s2_writedata,
    output logic [DATA_W-1:0] s2_readdata,
    output logic              s2_readdatavalid,
    output logic              s2_waitrequest
);

    localparam int c_RL    = (READ_LATENCY == RL_TWO) ? RL_TWO : RL_ONE;
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit c_unused_init = (INIT_FILE != "");

    logic [DATA_W-1:0] mem [DEPTH];

    mem_cmd_t          s1_cmd, s2_cmd;
    logic              w_en, w_collision;
    logic              w_s1_acc_rd, w_s1_wr_en, w_s1_in_range;
    logic              w_s2_acc_rd, w_s2_wr_en, w_s2_in_range;
    logic [c_IDX_W-1:0] w_s1_idx, w_s2_idx;
    logic [DATA_W-1:0] w_s1_rdata, w_s2_rdata;
    logic              w_unused_cmd;

    // Read+write on one port is a write; the read strobe is dropped.
    always_comb begin
        s1_cmd                    = '0;
        s1_cmd.addr[ADDR_W-1:0]   = s1_address;
        s1_cmd.be[BE_W-1:0]       = s1_byteenable;
        s1_cmd.wdata[DATA_W-1:0]  = s1_writedata;
        s1_cmd.wr                 = s1_chipselect & s1_write;
        s1_cmd.rd                 = s1_chipselect & s1_read & ~s1_write;
        s2_cmd                    = '0;
        s2_cmd.addr[ADDR_W-1:0]   = s2_address;
        s2_cmd.be[BE_W-1:0]       = s2_byteenable;
        s2_cmd.wdata[DATA_W-1:0]  = s2_writedata;
        s2_cmd.wr                 = s2_chipselect & s2_write;
        s2_cmd.rd                 = s2_chipselect & s2_read & ~s2_write;
    end

    assign w_en        = clken & ~reset_req;
    assign w_collision = s1_cmd.wr & s2_cmd.wr & (s1_cmd.addr == s2_cmd.addr);

    assign s1_waitrequest = ~w_en;
    assign s2_waitrequest = ~w_en | w_collision;

    assign w_s1_in_range = (s1_cmd.addr < MAX_ADDR_W'(DEPTH));
    assign w_s2_in_range = (s2_cmd.addr < MAX_ADDR_W'(DEPTH));
    assign w_s1_idx      = s1_cmd.addr[c_IDX_W-1:0];
    assign w_s2_idx      = s2_cmd.addr[c_IDX_W-1:0];

    assign w_s1_acc_rd = w_en & s1_cmd.rd;
    assign w_s2_acc_rd = w_en & ~w_collision & s2_cmd.rd;
    assign w_s1_wr_en  = w_en & s1_cmd.wr & w_s1_in_range;
    assign w_s2_wr_en  = w_en & ~w_collision & s2_cmd.wr & w_s2_in_range;

    // Combinational array read feeds the first pipe register, so a reader
    // sees the word as it stood before any write landing on the same edge.
    assign w_s1_rdata = w_s1_in_range ? mem[w_s1_idx] : '0;
    assign w_s2_rdata = w_s2_in_range ? mem[w_s2_idx] : '0;

    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (w_s1_wr_en && s1_cmd.be[b]) begin
                mem[w_s1_idx][8*b +: 8] <= s1_cmd.wdata[8*b +: 8];
            end
            if (w_s2_wr_en && s2_cmd.be[b]) begin
                mem[w_s2_idx][8*b +: 8] <= s2_cmd.wdata[8*b +: 8];
            end
        end
    end

    onchip_mem_rd_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (c_RL)
    ) u_s1_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_en),
        .i_valid (w_s1_acc_rd),
        .i_data  (w_s1_rdata),
        .o_valid (s1_readdatavalid),
        .o_data  (s1_readdata)
    );

    onchip_mem_rd_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (c_RL)
    ) u_s2_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_en),
        .i_valid (w_s2_acc_rd),
        .i_data  (w_s2_rdata),
        .o_valid (s2_readdatavalid),
        .o_data  (s2_readdata)
    );

    // Padding bits of the generic command record beyond this instance's widths.
    assign w_unused_cmd = ^{s1_cmd, s2_cmd, c_unused_init};

endmodule : qsys_onchip_mem_dp
`default_nettype wire

// File: tb/tb_qsys_onchip_mem_dp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qsys_onchip_mem_dp
//  Description : Scoreboard bench driving a latency-1 and a latency-2 memory
//                with identical directed traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qsys_onchip_mem_dp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clken, reset_req;
    logic [4:0]  s1_address, s2_address;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic        s1_chipselect, s1_read, s1_write;
    logic        s2_chipselect, s2_read, s2_write;
    logic [31:0] s1_writedata, s2_writedata;

    logic [31:0] d1_s1_rd, d1_s2_rd, d2_s1_rd, d2_s2_rd;
    logic        d1_s1_v, d1_s2_v, d2_s1_v, d2_s2_v;
    logic        d1_s1_w, d1_s2_w, d2_s1_w, d2_s2_w;

    qsys_onchip_mem_dp #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .READ_LATENCY(1), .INIT_FILE("")) u_dut_l1 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_readdata(d1_s1_rd), .s1_readdatavalid(d1_s1_v), .s1_waitrequest(d1_s1_w),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
        .s2_readdata(d1_s2_rd), .s2_readdatavalid(d1_s2_v), .s2_waitrequest(d1_s2_w)
    );

    qsys_onchip_mem_dp #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .READ_LATENCY(2), .INIT_FILE("")) u_dut_l2 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_readdata(d2_s1_rd), .s1_readdatavalid(d2_s1_v), .s1_waitrequest(d2_s1_w),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
        .s2_readdata(d2_s2_rd), .s2_readdatavalid(d2_s2_v), .s2_waitrequest(d2_s2_w)
    );

    typedef struct {
        int          dut;
        int          port;
        int          at;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_rd(input int dut, input int port, input int at, input logic [31:0] data);
        exp_t e;
        e.dut = dut; e.port = port; e.at = at; e.data = data;
        sb.push_back(e);
    endtask

    task automatic expect_both(input int port, input logic [31:0] data);
        expect_rd(1, port, cyc + 1, data);
        expect_rd(2, port, cyc + 2, data);
    endtask

    task automatic mon(input int dut, input int port, input logic v, input logic [31:0] d);
        int idx;
        idx = -1;
        if (v === 1'b1) begin
            foreach (sb[i]) if (idx < 0 && sb[i].dut == dut && sb[i].port == port) idx = i;
            n_chk++;
            if (idx < 0) begin
                n_fail++;
                $display("FAIL rdv_unexpected l%0d s%0d: got valid data %h at cycle %0d, required no valid",
                         dut, port, d, cyc);
            end else begin
                if (sb[idx].at != cyc || sb[idx].data !== d) begin
                    n_fail++;
                    $display("FAIL rdata l%0d s%0d: got %h at cycle %0d, required %h at cycle %0d",
                             dut, port, d, cyc, sb[idx].data, sb[idx].at);
                end
                sb.delete(idx);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1, 1, d1_s1_v, d1_s1_rd);
        mon(1, 2, d1_s2_v, d1_s2_rd);
        mon(2, 1, d2_s1_v, d2_s1_rd);
        mon(2, 2, d2_s2_v, d2_s2_rd);
    end

    task automatic s1_drive(input logic rd, input logic wr, input logic [4:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
        s1_chipselect = rd | wr; s1_read = rd; s1_write = wr;
        s1_address = a; s1_byteenable = be; s1_writedata = wd;
    endtask

    task automatic s2_drive(input logic rd, input logic wr, input logic [4:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
        s2_chipselect = rd | wr; s2_read = rd; s2_write = wr;
        s2_address = a; s2_byteenable = be; s2_writedata = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s1_drive(0, 0, 0, 0, 0);
        s2_drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        int d;
        reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
        idle();
        repeat (3) step();
        chk("reset_l1_s1_rdv",   {31'b0, d1_s1_v}, 32'd0);
        chk("reset_l2_s2_rdv",   {31'b0, d2_s2_v}, 32'd0);
        chk("reset_l1_s2_rdata", d1_s2_rd, 32'd0);
        chk("reset_l2_s1_rdata", d2_s1_rd, 32'd0);
        chk("reset_s1_wait",     {31'b0, d1_s1_w}, 32'd0);
        chk("reset_s2_wait",     {31'b0, d2_s2_w}, 32'd0);
        reset = 1'b0;

        // Write then read-after-write on one port
        s1_drive(0, 1, 5, 4'hF, 32'hDEADBEEF); step();
        s1_drive(1, 0, 5, 0, 0); expect_both(1, 32'hDEADBEEF); step();

        // Byte lanes, and an all-zero byteenable write that must not disturb
        s1_drive(0, 1, 6, 4'hF, 32'hAABBCCDD); step();
        s1_drive(0, 0, 0, 0, 0); s2_drive(0, 1, 6, 4'b0101, 32'h11223344); step();
        s2_drive(0, 0, 0, 0, 0); s1_drive(1, 0, 6, 0, 0); expect_both(1, 32'hAA22CC44); step();
        s1_drive(0, 0, 0, 0, 0); s2_drive(0, 1, 6, 4'b0000, 32'hFFFFFFFF); step();
        s2_drive(1, 0, 6, 0, 0); expect_both(2, 32'hAA22CC44); step();
        idle();

        // Same-address collision: s1 first, s2 stalls one cycle and lands last
        s1_drive(0, 1, 7, 4'hF, 32'h1); s2_drive(0, 1, 7, 4'hF, 32'h2); #1;
        chk("coll_l1_s2_wait", {31'b0, d1_s2_w}, 32'd1);
        chk("coll_l2_s2_wait", {31'b0, d2_s2_w}, 32'd1);
        chk("coll_l1_s1_wait", {31'b0, d1_s1_w}, 32'd0);
        step();
        s1_drive(0, 0, 0, 0, 0); #1;
        chk("coll_retry_s2_wait", {31'b0, d1_s2_w}, 32'd0);
        step();
        s2_drive(0, 0, 0, 0, 0); s1_drive(1, 0, 7, 0, 0); expect_both(1, 32'h2); step();

        // Dual writes to different addresses proceed together
        s1_drive(0, 1, 8, 4'hF, 32'h0A0A0A0A); s2_drive(0, 1, 9, 4'hF, 32'h0B0B0B0B); #1;
        chk("nocoll_s2_wait", {31'b0, d2_s2_w}, 32'd0);
        step();
        s1_drive(1, 0, 8, 0, 0); s2_drive(1, 0, 9, 0, 0);
        expect_both(1, 32'h0A0A0A0A); expect_both(2, 32'h0B0B0B0B); step();

        // Mixed-port read during write returns old data
        s2_drive(0, 0, 0, 0, 0); s1_drive(0, 1, 3, 4'hF, 32'h99); step();
        s1_drive(0, 1, 3, 4'hF, 32'h55); s2_drive(1, 0, 3, 0, 0); expect_both(2, 32'h99); step();
        s1_drive(0, 0, 0, 0, 0); s2_drive(1, 0, 3, 0, 0); expect_both(2, 32'h55); step();

        // Read+write together is a write with no return
        s2_drive(0, 0, 0, 0, 0); s1_drive(1, 1, 10, 4'hF, 32'h77); step();
        s1_drive(1, 0, 10, 0, 0); expect_both(1, 32'h77); step();

        // Out-of-range address: write dropped (no aliasing), read returns zero
        s1_drive(0, 1, 4, 4'hF, 32'h44444444); step();
        s1_drive(0, 1, 20, 4'hF, 32'h1234); step();
        s1_drive(1, 0, 4, 0, 0); expect_both(1, 32'h44444444); step();
        s1_drive(1, 0, 20, 0, 0); expect_both(1, 32'h0); step();

        // Back-to-back reads, reset with the third still in the latency-2 pipe
        s1_drive(0, 1, 0, 4'hF, 32'h100); s2_drive(0, 1, 1, 4'hF, 32'h101); step();
        s1_drive(0, 1, 2, 4'hF, 32'h102); s2_drive(0, 0, 0, 0, 0); step();
        s1_drive(1, 0, 0, 0, 0); expect_both(1, 32'h100); step();
        s1_drive(1, 0, 1, 0, 0); expect_both(1, 32'h101); step();
        s1_drive(1, 0, 2, 0, 0); expect_rd(1, 1, cyc + 1, 32'h102); step();
        s1_drive(0, 0, 0, 0, 0); reset = 1'b1; step();
        reset = 1'b0;
        chk("rst_inflight_l2_rdv",   {31'b0, d2_s1_v}, 32'd0);
        chk("rst_inflight_l2_rdata", d2_s1_rd, 32'd0);
        chk("rst_inflight_l1_rdata", d1_s1_rd, 32'd0);
        step();

        // Freeze with reads in flight and writes pending, then resume
        s1_drive(1, 0, 5, 0, 0); s2_drive(1, 0, 6, 0, 0);
        d = cyc;
        expect_rd(1, 1, d + 4, 32'hDEADBEEF); expect_rd(1, 2, d + 4, 32'hAA22CC44);
        expect_rd(2, 1, d + 5, 32'hDEADBEEF); expect_rd(2, 2, d + 5, 32'hAA22CC44);
        step();
        reset_req = 1'b1;
        s1_drive(0, 1, 5, 4'hF, 32'hFFFF0000); s2_drive(0, 1, 6, 4'hF, 32'h0); #1;
        chk("freeze_l1_s1_wait", {31'b0, d1_s1_w}, 32'd1);
        chk("freeze_l1_s2_wait", {31'b0, d1_s2_w}, 32'd1);
        chk("freeze_l2_s1_wait", {31'b0, d2_s1_w}, 32'd1);
        chk("freeze_l2_s2_wait", {31'b0, d2_s2_w}, 32'd1);
        step(); step();
        reset_req = 1'b0; clken = 1'b0; #1;
        chk("clken_off_s1_wait", {31'b0, d1_s1_w}, 32'd1);
        step();
        clken = 1'b1; idle(); step();
        s1_drive(1, 0, 5, 0, 0); s2_drive(1, 0, 6, 0, 0);
        expect_both(1, 32'hDEADBEEF); expect_both(2, 32'hAA22CC44); step();
        idle();
        repeat (5) step();

        foreach (sb[i]) begin
            n_chk++;
            n_fail++;
            $display("FAIL rdv_missing l%0d s%0d: got no valid, required %h at cycle %0d",
                     sb[i].dut, sb[i].port, sb[i].data, sb[i].at);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_qsys_onchip_mem_dp
`default_nettype wire
